// File: rtl/float_sort_pkg.sv
// float_sort_pkg: shared types, float format and pass-end helper for float_sort_sequencer
//   FLEN/EXP_W/FRAC_W : IEEE-754 binary64 layout used by the sorter and comparator
//   sort_state_t      : LOAD / SORT / OUT
//   pass_end(n, pass) : last compare index of a bubble pass (n-2-pass)
package float_sort_pkg;
    localparam int FLEN = 64;
    localparam int EXP_W = 11;
    localparam int FRAC_W = 52;
    typedef enum logic [1:0] {LOAD, SORT, OUT} sort_state_t;
    function automatic int unsigned pass_end(input int unsigned n, input int unsigned pass);
        return n - 2 - pass;
    endfunction
endpackage

// File: rtl/f_less_or_equal.sv
// f_less_or_equal: combinational IEEE-754 a <= b compare with NaN/Inf error flag
//   a, b : operands (FLEN bits)
//   res  : 1 when a <= b (+0 == -0); 0 when either operand is NaN
//   err  : 1 when either operand is NaN or Inf
module f_less_or_equal
    import float_sort_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    logic a_spec, b_spec, a_nan, b_nan, both_zero;
    logic [FLEN-2:0] a_mag, b_mag;
    assign a_mag = a[FLEN-2:0];
    assign b_mag = b[FLEN-2:0];
    assign a_spec = &a[FLEN-2 -: EXP_W];
    assign b_spec = &b[FLEN-2 -: EXP_W];
    assign a_nan = a_spec && |a[FRAC_W-1:0];
    assign b_nan = b_spec && |b[FRAC_W-1:0];
    assign both_zero = ~|a_mag && ~|b_mag;
    assign err = a_spec || b_spec;
    // sign-magnitude order: negatives compare with reversed magnitude
    assign res = (a_nan || b_nan) ? 1'b0 :
                 both_zero ? 1'b1 :
                 (a[FLEN-1] != b[FLEN-1]) ? a[FLEN-1] :
                 a[FLEN-1] ? (a_mag >= b_mag) : (a_mag <= b_mag);
endmodule

// File: rtl/float_sort_sequencer.sv
// float_sort_sequencer: loads N floats, bubble-sorts them with one shared comparator, streams them out ascending
//   clk, rst                      : clock, synchronous active-high reset
//   up_valid, up_data, up_ready   : input stream (accepted only in LOAD)
//   down_valid, down_data         : sorted output stream, held while !down_ready
//   down_last, down_err           : last element marker, sticky NaN/Inf flag of the burst
//   down_ready                    : downstream accept
module float_sort_sequencer
    import float_sort_pkg::*;
#(
    parameter  int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    input  logic [FLEN-1:0] up_data,
    output logic            up_ready,
    output logic            down_valid,
    output logic [FLEN-1:0] down_data,
    output logic            down_last,
    output logic            down_err,
    input  logic            down_ready
);
    sort_state_t state;
    logic [FLEN-1:0] buffer [N];
    logic [IDX_W-1:0] wr_idx, rd_idx, i, pass, i_nx;
    logic swapped, err_sticky, res, cmp_err, sw_now;
    logic [FLEN-1:0] op_a, op_b;
    assign i_nx = i + IDX_W'(1);
    assign op_a = buffer[i];
    assign op_b = buffer[i_nx];
    // swapped must include this cycle's compare when deciding at pass end
    assign sw_now = swapped || !res;
    assign up_ready = state == LOAD;
    assign down_valid = state == OUT;
    assign down_data = buffer[rd_idx];
    assign down_last = state == OUT && rd_idx == IDX_W'(N - 1);
    assign down_err = state == OUT && err_sticky;
    f_less_or_equal u_cmp (
        .a  (op_a),
        .b  (op_b),
        .res(res),
        .err(cmp_err)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            wr_idx <= '0;
            rd_idx <= '0;
            i <= '0;
            pass <= '0;
            swapped <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            case (state)
                LOAD: if (up_valid) begin
                    buffer[wr_idx] <= up_data;
                    wr_idx <= wr_idx + IDX_W'(1);
                    if (wr_idx == IDX_W'(N - 1)) begin
                        state <= SORT;
                        wr_idx <= '0;
                        i <= '0;
                        pass <= '0;
                        swapped <= 1'b0;
                    end
                end
                SORT: begin
                    if (!res) begin
                        buffer[i] <= op_b;
                        buffer[i_nx] <= op_a;
                    end
                    if (cmp_err) err_sticky <= 1'b1;
                    if (i == IDX_W'(pass_end(N, 32'(pass)))) begin
                        if (!sw_now || pass == IDX_W'(N - 2)) begin
                            state <= OUT;
                            rd_idx <= '0;
                        end else begin
                            pass <= pass + IDX_W'(1);
                            i <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        i <= i_nx;
                        swapped <= sw_now;
                    end
                end
                OUT: if (down_ready) begin
                    rd_idx <= rd_idx + IDX_W'(1);
                    if (rd_idx == IDX_W'(N - 1)) begin
                        state <= LOAD;
                        rd_idx <= '0;
                        wr_idx <= '0;
                        err_sticky <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: doc/float_sort_sequencer.md
Name: float_sort_sequencer

Overview:
Sequential sorter that sorts a burst of N floating-point numbers using a single shared f_less_or_equal comparator. It is the multi-cycle, area-lean counterpart to the combinational sort networks.
- Input side: accepts N FLEN-bit values over a valid/ready stream into an internal buffer.
- Sort phase: runs bubble-sort passes with exactly one comparison per cycle.
- Output side: streams the result in increasing order with a last marker and a sticky error flag.

Parameters:
- N, 8, number of elements per burst; legal range 2..64.
- IDX_W, $clog2(N), width of the element index and pass counters (derived; not to be overridden).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- up_valid, input, 1, upstream data valid.
- up_data, input, FLEN, upstream float (FLEN from config-shared.vh).
- up_ready, output, 1, block can accept up_data this cycle.
- down_valid, output, 1, sorted output valid.
- down_data, output, FLEN, sorted float.
- down_last, output, 1, marks element N-1 of the sorted burst.
- down_err, output, 1, sticky error for the current burst; valid with down_valid.
- down_ready, input, 1, downstream accepts the output this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=LOAD, all counters 0, err_sticky=0.
  - up_ready=1 in the first cycle after reset.
  - down_valid=0, down_last=0, down_err=0.
  - Buffer contents are don't-care.
  - rst has priority over every other event, mid-LOAD/SORT/OUT included; a partial burst is discarded.
- FSM states: LOAD, SORT, OUT.
- LOAD:
  - up_ready=1.
  - On up_valid&&up_ready: buf[wr_idx]<=up_data, then wr_idx++.
  - When the element at wr_idx=N-1 is accepted: go to SORT with i=0, pass=0, swapped=0.
  - up_ready=0 in all other states.
- SORT:
  - Comparator inputs are a=buf[i], b=buf[i+1]; one compare per cycle, no stall.
  - If res=0: swap buf[i] and buf[i+1] and set swapped=1. If res=1 (equal values included): no swap, which keeps the sort stable.
  - Comparator err=1 in any SORT cycle sets err_sticky.
  - i runs 0..N-2-pass. Each pass shrinks by one, because the maximum settles at the end.
  - At end of pass (i==N-2-pass):
    - If swapped==0 for the whole pass, including this cycle's compare, or pass==N-2: go to OUT.
    - Otherwise pass++, i=0, swapped=0.
  - SORT duration: minimum N-1 cycles (already-sorted input); maximum N(N-1)/2 cycles (reverse-sorted input).
- OUT:
  - down_valid=1, down_data=buf[rd_idx], down_last=(rd_idx==N-1), down_err=err_sticky.
  - On down_valid&&down_ready: rd_idx++.
  - On the transfer with down_last=1: rd_idx=0, wr_idx=0, err_sticky=0, go to LOAD.
  - down_data is held stable while down_valid&&!down_ready.
- No overlap between bursts: a new burst is not accepted until the final output transfer has completed.
- Latency from last input accept to first down_valid: SORT cycles + 1; the first down_valid is in the cycle after SORT exits.
- Error handling:
  - A NaN/Inf operand does not abort the sort. The order is whatever the comparator's res dictates.
  - down_err=1 for every element of that burst.
- All outputs are registered or decoded from registered state only. There is no combinational path from up_* or down_ready to any output except through state.

Decomposition:
- Package float_sort_pkg:
  - typedef enum logic [1:0] {LOAD, SORT, OUT} sort_state_t.
  - Helper for the pass-end index N-2-pass.
- Sub-module: exactly one instance of the existing f_less_or_equal. No new sub-module; the datapath stays inline.

Test Plan:
FP64 encodings used below: 1.0=3FF0000000000000, 2.0=4000000000000000, -1.0=BFF0000000000000, 0.0=0000000000000000, qNaN=7FF8000000000000.
- N=4, input {2.0, 1.0, -1.0, 0.0}, down_ready=1 -> output {-1.0, 0.0, 1.0, 2.0}; down_last only on 2.0; down_err=0; SORT lasts ≤6 cycles.
- N=4, already-sorted {-1.0, 0.0, 1.0, 2.0} -> SORT exits after exactly 3 cycles; output identical to input.
- Reverse-sorted N=8 input (8.0 down to 1.0) -> SORT lasts exactly 28 cycles; ascending output.
- N=4, input {1.0, qNaN, 0.0, 2.0} -> all 4 outputs carry down_err=1. The next clean burst outputs down_err=0.
- down_ready toggling 1/0 every cycle during OUT -> each element is presented stable until accepted; none duplicated or lost; up_ready=0 throughout OUT.
- rst=1 asserted in the middle of SORT, then a fresh burst {0.0, 2.0, 1.0, -1.0} -> correct sorted output; no residue from the aborted burst.
